mips_bus_arbiter: RTL and testbench
===================================

Name: mips_bus_arbiter

Overview:
- Two-master to one-slave arbiter for the CPU memory bus.
- Master 0 is the instruction-fetch port and is read-only. Master 1 is the load/store port.
- Both masters share one Avalon-style slave port (address/read/write/writedata/byteenable/waitrequest/readdata) that drives the bench RAM or the system memory.
- Sits between the CPU core ports and the external bus; arbitration is round-robin, one transfer at a time.

Parameters:
- AW, 32, address width
- DW, 32, data width; byteenable width is DW/8

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- m0_address  in  AW  fetch address
- m0_read  in  1  fetch request
- m0_waitrequest  out  1  stall to fetch port
- m0_readdata  out  DW  fetch data
- m0_readdatavalid  out  1  fetch data valid strobe
- m1_address  in  AW  load/store address
- m1_read  in  1  load request
- m1_write  in  1  store request
- m1_writedata  in  DW  store data
- m1_byteenable  in  DW/8  byte lanes
- m1_waitrequest  out  1  stall to load/store port
- m1_readdata  out  DW  load data
- m1_readdatavalid  out  1  load data valid strobe
- s_address  out  AW  to slave
- s_read  out  1  to slave
- s_write  out  1  to slave
- s_writedata  out  DW  to slave
- s_byteenable  out  DW/8  to slave
- s_waitrequest  in  1  slave stall
- s_readdata  in  DW  slave data; valid exactly 1 cycle after read acceptance

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Transfer acceptance: a transfer is accepted on a rising edge where the granted request is high and s_waitrequest=0. Masters hold address/data/request stable while their waitrequest is 1.
- States:
  - IDLE: no grant.
  - BUS: owner registered; slave signals muxed from the owner.
  - RDATA: owner's read data returning.
- Registers: state, owner (0/1), last_grant (0/1).
- IDLE transitions:
  - No requests: stay.
  - One requester: owner := that master, go BUS.
  - Both requesting: owner := !last_grant, go BUS.
  - In all grant cases last_grant := owner.
- BUS transitions:
  - Owner request dropped: go IDLE, no slave transfer (abort).
  - Accepted write: go IDLE.
  - Accepted read: go RDATA.
  - Otherwise stay.
- RDATA: go IDLE unconditionally.
- Slave outputs:
  - In BUS: s_address/s_writedata/s_byteenable/s_read/s_write come combinationally from the owner.
  - m0 drives s_write=0, s_writedata=0, s_byteenable=4'b1111.
  - Outside BUS: s_read=s_write=0, s_address=0, s_writedata=0, s_byteenable=0.
- m1 read+write both high: write wins; s_read=0.
- Waitrequest:
  - mX_waitrequest = s_waitrequest when state=BUS and owner=X.
  - Otherwise mX_waitrequest=1. The non-owner is always stalled.
- Read return: m0_readdata = m1_readdata = s_readdata (broadcast). mX_readdatavalid = (state=RDATA && owner=X); it is a single-cycle pulse.
- Latency with idle bus and zero slave wait:
  - Request seen at edge 0; BUS from cycle 1; accepted at edge 1 → RDATA in cycle 2 with readdatavalid high.
  - Reads take 3 cycles per transfer; writes take 2.
- Reset values: state=IDLE, owner=0, last_grant=1 (fetch wins the first tie), all slave strobes 0, both waitrequests 1, both readdatavalid 0.
- Reset mid-transfer: IDLE on the next edge. Any pending RDATA pulse is suppressed, and the slave strobe drops in the cycle after the reset edge.
- Simultaneous new request from the non-owner during RDATA: it is considered only in the next IDLE cycle; there is no grant bypass.

Test Plan:
1. Reset held 2 cycles, then released → m0/m1_waitrequest=1, s_read=s_write=0, readdatavalid=0 until first grant.
2. m0 read of 0xBFC00000, memory word 0x3C02F000, s_waitrequest=0 → s_read=1 with s_address=0xBFC00000 in cycle 1; m0_readdatavalid=1 with m0_readdata=0x3C02F000 in cycle 2 only.
3. m0 read 0xBFC00004 and m1 write 0x0000F000 to 0xBFC00100 with byteenable=4'b1111, both requesting from reset → m0 is granted first. m1 is then granted, and afterwards memory[0x40]=0x0000F000; m1_waitrequest=1 throughout m0's BUS/RDATA.
4. Both masters request continuously for 4 transfers → grant order m0,m1,m0,m1; no master is granted twice in a row.
5. m1 read with s_waitrequest=1 for 3 cycles → stays BUS; s_read stays asserted with a stable address; m1_waitrequest=1. Acceptance comes on the 4th edge, then m1_readdatavalid pulses once.
6. Reset asserted during RDATA of an m1 read → m1_readdatavalid=0, and state=IDLE on the next cycle. A subsequent m0 read completes normally with a 2-cycle request-to-data latency.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter letting the instruction-fetch port (m0, read-only) and the
// load/store port (m1) share one Avalon-style slave, one transfer at a time.
module mips_bus_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset,

   input  logic [AW-1:0]   m0_address,
   input  logic            m0_read,
   output logic            m0_waitrequest,
   output logic [DW-1:0]   m0_readdata,
   output logic            m0_readdatavalid,

   input  logic [AW-1:0]   m1_address,
   input  logic            m1_read,
   input  logic            m1_write,
   input  logic [DW-1:0]   m1_writedata,
   input  logic [DW/8-1:0] m1_byteenable,
   output logic            m1_waitrequest,
   output logic [DW-1:0]   m1_readdata,
   output logic            m1_readdatavalid,

   output logic [AW-1:0]   s_address,
   output logic            s_read,
   output logic            s_write,
   output logic [DW-1:0]   s_writedata,
   output logic [DW/8-1:0] s_byteenable,
   input  logic            s_waitrequest,
   input  logic [DW-1:0]   s_readdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS   = 2'd1,
      RDATA = 2'd2
   } state_t;

   state_t state_reg, state_next;
   logic   owner_reg, owner_next;
   logic   last_grant_reg, last_grant_next;

   logic [1:0] req;
   logic       owner_req;
   logic       owner_wants_write;
   logic [1:0] wait_vec;
   logic [1:0] valid_vec;

   // m1 with read and write both high is a write, so any m1 strobe is a request
   assign req[0]            = m0_read;
   assign req[1]            = m1_read | m1_write;
   assign owner_req         = req[owner_reg];
   assign owner_wants_write = owner_reg & m1_write;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_grant_reg <= last_grant_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_grant_next = last_grant_reg;
      case (state_reg)
         IDLE: begin
            if (req != 2'b00) begin
               if (req == 2'b11) owner_next = ~last_grant_reg;
               else              owner_next = req[1];
               last_grant_next = owner_next;
               state_next      = BUS;
            end
         end
         BUS: begin
            // a dropped request abandons the grant without a slave transfer
            if (!owner_req)          state_next = IDLE;
            else if (!s_waitrequest) state_next = owner_wants_write ? IDLE : RDATA;
         end
         RDATA:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      s_address    = '0;
      s_read       = 1'b0;
      s_write      = 1'b0;
      s_writedata  = '0;
      s_byteenable = '0;
      if (state_reg == BUS) begin
         if (owner_reg) begin
            s_address    = m1_address;
            s_write      = m1_write;
            s_read       = m1_read & ~m1_write;
            s_writedata  = m1_writedata;
            s_byteenable = m1_byteenable;
         end else begin
            s_address    = m0_address;
            s_read       = m0_read;
            s_byteenable = '1;
         end
      end
   end

   // valid is gated by reset so a read caught by reset never reports data
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_master
         assign wait_vec[gi]  = (state_reg == BUS && owner_reg == (gi == 1)) ? s_waitrequest : 1'b1;
         assign valid_vec[gi] = (state_reg == RDATA) && (owner_reg == (gi == 1)) && !reset;
      end
   endgenerate

   assign m0_waitrequest   = wait_vec[0];
   assign m1_waitrequest   = wait_vec[1];
   assign m0_readdatavalid = valid_vec[0];
   assign m1_readdatavalid = valid_vec[1];
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: directed cycle checks, a vector table, and a
// randomized run scored against a transaction-level memory/round-robin model.
module tb_mips_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] m0_address = '0;
   logic        m0_read = 1'b0;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m0_readdatavalid;
   logic [31:0] m1_address = '0;
   logic        m1_read = 1'b0;
   logic        m1_write = 1'b0;
   logic [31:0] m1_writedata = '0;
   logic [3:0]  m1_byteenable = '0;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        m1_readdatavalid;
   logic [31:0] s_address;
   logic        s_read;
   logic        s_write;
   logic [31:0] s_writedata;
   logic [3:0]  s_byteenable;
   logic        s_waitrequest = 1'b0;
   logic [31:0] s_readdata;

   always #5 clk = ~clk;

   mips_bus_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
   );

   // slave RAM: word index from address[9:2], read data valid one cycle after acceptance
   logic [31:0] mem [0:255];
   logic        bk_we = 1'b0;
   logic [7:0]  bk_idx = '0;
   logic [31:0] bk_data = '0;

   always @(posedge clk) begin : slave
      logic        rd_hit;
      logic [31:0] rd_val;
      rd_hit = s_read && !s_waitrequest;
      rd_val = mem[s_address[9:2]];
      if (s_write && !s_waitrequest)
         for (int b = 0; b < 4; b++)
            if (s_byteenable[b]) mem[s_address[9:2]][8*b +: 8] = s_writedata[8*b +: 8];
      if (bk_we) mem[bk_idx] = bk_data;
      #1;
      s_readdata = rd_hit ? rd_val : 32'hDEAD_BEEF;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      m0_read = 1'b0; m0_address = '0;
      m1_read = 1'b0; m1_write = 1'b0; m1_address = '0;
      m1_writedata = '0; m1_byteenable = '0;
      s_waitrequest = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic poke(input logic [7:0] idx, input logic [31:0] val);
      bk_idx = idx; bk_data = val; bk_we = 1'b1;
      step();
      bk_we = 1'b0;
   endtask

   typedef struct {
      logic        mst;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        exp_sread;
      logic        exp_swrite;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vecs [8];
   vec_t        v;
   int          order [4];
   int          got;
   int          pulses;
   logic [31:0] shadow [16];
   bit          acc0, acc1, pr0, pr1, other_req;
   logic [31:0] d0, d1, val;
   int          who, must, n_acc, k;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF, 1'b0, 1'b1, 4'hF, 32'h11223344, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'h5, 1'b0, 1'b1, 4'h5, 32'hAABBCCDD, 32'h0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h55555555, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0,        32'h11BB33DD};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h0BAD0BAD, 4'hF, 1'b1, 1'b0, 4'hF, 32'h0BAD0BAD, 32'h11BB33DD};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h44, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h44, 32'h12345678, 4'h3, 1'b1, 1'b0, 4'hF, 32'h0,        32'hCAFEF00D};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h44, 32'h00000000, 4'h8, 1'b0, 1'b1, 4'h8, 32'h0,        32'h0};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h44, 32'h00000000, 4'h3, 1'b1, 1'b0, 4'h3, 32'h0,        32'h00FEF00D};

      // reset state after release
      do_reset();
      for (int c = 0; c < 3; c++) begin
         neg();
         chk("t1_m0_wait", m0_waitrequest, 1);
         chk("t1_m1_wait", m1_waitrequest, 1);
         chk("t1_strobes", {s_read, s_write}, 0);
         chk("t1_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
      end

      // single fetch, zero wait
      poke(8'h00, 32'h3C02F000);
      do_reset();
      m0_address = 32'hBFC00000; m0_read = 1'b1;
      neg(); chk("t2_c0_sread", s_read, 0);
      neg(); chk("t2_c1_sread", s_read, 1);
             chk("t2_c1_saddr", s_address, 32'hBFC00000);
             chk("t2_c1_m0wait", m0_waitrequest, 0);
             chk("t2_c1_rdv", m0_readdatavalid, 0);
      step(); m0_read = 1'b0;
      neg(); chk("t2_c2_rdv", m0_readdatavalid, 1);
             chk("t2_c2_data", m0_readdata, 32'h3C02F000);
             chk("t2_c2_m1rdv", m1_readdatavalid, 0);
      neg(); chk("t2_c3_rdv", m0_readdatavalid, 0);

      // reset during RDATA, then a clean fetch
      do_reset();
      m1_address = 32'h48; m1_read = 1'b1;
      neg();
      neg(); chk("t6_c1_sread", s_read, 1);
      step(); m1_read = 1'b0; reset = 1'b1;
      neg(); chk("t6_rdv_suppressed", m1_readdatavalid, 0);
      step(); reset = 1'b0; m0_address = 32'hBFC00000; m0_read = 1'b1;
      neg(); chk("t6_idle_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
             chk("t6_idle_sread", s_read, 0);
             chk("t6_idle_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
      neg(); chk("t6_bus_saddr", s_address, 32'hBFC00000);
      step(); m0_read = 1'b0;
      neg(); chk("t6_m0_rdv", m0_readdatavalid, 1);
             chk("t6_m0_data", m0_readdata, 32'h3C02F000);

      // simultaneous requests from reset: fetch first
      poke(8'h01, 32'h24420001);
      do_reset();
      m0_address = 32'hBFC00004; m0_read = 1'b1;
      m1_address = 32'hBFC00100; m1_write = 1'b1;
      m1_writedata = 32'h0000F000; m1_byteenable = 4'hF;
      neg(); chk("t3_c0_m1wait", m1_waitrequest, 1);
      neg(); chk("t3_c1_sread", s_read, 1);
             chk("t3_c1_saddr", s_address, 32'hBFC00004);
             chk("t3_c1_m0wait", m0_waitrequest, 0);
             chk("t3_c1_m1wait", m1_waitrequest, 1);
      step(); m0_read = 1'b0;
      neg(); chk("t3_c2_rdv", m0_readdatavalid, 1);
             chk("t3_c2_data", m0_readdata, 32'h24420001);
             chk("t3_c2_m1wait", m1_waitrequest, 1);
      neg(); chk("t3_c3_m1wait", m1_waitrequest, 1);
      neg(); chk("t3_c4_swrite", s_write, 1);
             chk("t3_c4_saddr", s_address, 32'hBFC00100);
             chk("t3_c4_swd", s_writedata, 32'h0000F000);
             chk("t3_c4_m1wait", m1_waitrequest, 0);
      step(); m1_write = 1'b0;
      neg(); chk("t3_mem", mem[8'h40], 32'h0000F000);

      // continuous contention alternates
      do_reset();
      m0_address = 32'hBFC00008; m0_read = 1'b1;
      m1_address = 32'hBFC00200; m1_read = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
         neg();
         if (m0_read && !m0_waitrequest)      begin order[got] = 0; got++; end
         else if (m1_read && !m1_waitrequest) begin order[got] = 1; got++; end
      end
      chk("t4_count", got, 4);
      for (int i = 0; i < got; i++) chk("t4_order", order[i], i % 2);

      // slave stall on an m1 read
      poke(8'h12, 32'h5A5A1234);
      do_reset();
      s_waitrequest = 1'b1; m1_address = 32'h48; m1_read = 1'b1;
      neg();
      for (int c = 1; c <= 3; c++) begin
         neg();
         chk("t5_stall_sread", s_read, 1);
         chk("t5_stall_saddr", s_address, 32'h48);
         chk("t5_stall_m1wait", m1_waitrequest, 1);
      end
      step(); s_waitrequest = 1'b0;
      neg(); chk("t5_accept_m1wait", m1_waitrequest, 0);
      step(); m1_read = 1'b0;
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
         neg();
         if (m1_readdatavalid) begin
            pulses++;
            chk("t5_data", m1_readdata, 32'h5A5A1234);
         end
      end
      chk("t5_pulses", pulses, 1);

      // owner drops its request while stalled: no transfer
      poke(8'h13, 32'h77777777);
      do_reset();
      s_waitrequest = 1'b1; m1_address = 32'h4C; m1_write = 1'b1;
      m1_writedata = 32'h12345678; m1_byteenable = 4'hF;
      neg();
      neg(); chk("t7_c1_swrite", s_write, 1);
      step(); m1_write = 1'b0; s_waitrequest = 1'b0;
      neg(); chk("t7_c2_swrite", s_write, 0);
      neg(); chk("t7_c3_m1wait", m1_waitrequest, 1);
             chk("t7_c3_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
             chk("t7_mem", mem[8'h13], 32'h77777777);

      // vector table, each transfer from an idle bus with zero wait
      do_reset();
      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         step();
         m1_writedata = v.wd; m1_byteenable = v.be;
         if (v.mst) begin m1_address = v.addr; m1_read = v.rd; m1_write = v.wr; end
         else       begin m0_address = v.addr; m0_read = v.rd; end
         neg(); chk("tab_c0_wait", v.mst ? m1_waitrequest : m0_waitrequest, 1);
         neg(); chk("tab_sread", s_read, v.exp_sread);
                chk("tab_swrite", s_write, v.exp_swrite);
                chk("tab_saddr", s_address, v.addr);
                chk("tab_sbe", s_byteenable, v.exp_be);
                chk("tab_swd", s_writedata, v.exp_wd);
                chk("tab_wait", v.mst ? m1_waitrequest : m0_waitrequest, 0);
         step(); m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
         neg(); chk("tab_rdv", v.mst ? m1_readdatavalid : m0_readdatavalid, v.exp_sread);
                chk("tab_other_rdv", v.mst ? m0_readdatavalid : m1_readdatavalid, 0);
                if (v.exp_sread) chk("tab_rdata", v.mst ? m1_readdata : m0_readdata, v.exp_rdata);
         neg(); chk("tab_idle", {s_read, s_write, m0_readdatavalid, m1_readdatavalid}, 0);
      end

      // randomized traffic against a transaction-level model
      do_reset();
      for (int i = 0; i < 16; i++) begin
         val = $urandom;
         poke(8'(8'h80 + i), val);
         shadow[i] = val;
      end
      pr0 = 1'b0; pr1 = 1'b0; must = -1; n_acc = 0;
      for (int c = 0; c < 4000; c++) begin
         if (c < 3500) begin
            if (!m0_read && $urandom_range(2) == 0) begin
               m0_read = 1'b1;
               m0_address = 32'h200 + 32'(4 * $urandom_range(15));
            end
            if (!(m1_read || m1_write) && $urandom_range(2) == 0) begin
               k = $urandom_range(3);
               m1_read  = (k == 0 || k == 1 || k == 3);
               m1_write = (k == 2 || k == 3);
               m1_address = 32'h200 + 32'(4 * $urandom_range(15));
               m1_writedata = $urandom;
               m1_byteenable = 4'($urandom_range(15));
            end
         end
         s_waitrequest = ($urandom_range(3) == 0);
         neg();
         chk("rnd_one_owner", m0_waitrequest | m1_waitrequest, 1);
         chk("rnd_m0_rdv", m0_readdatavalid, pr0);
         chk("rnd_m1_rdv", m1_readdatavalid, pr1);
         if (pr0) chk("rnd_m0_data", m0_readdata, d0);
         if (pr1) chk("rnd_m1_data", m1_readdata, d1);
         pr0 = 1'b0; pr1 = 1'b0;
         acc0 = m0_read && !m0_waitrequest;
         acc1 = (m1_read || m1_write) && !m1_waitrequest;
         if (acc0 || acc1) begin
            n_acc++;
            who = acc1 ? 1 : 0;
            if (must >= 0) chk("rnd_rr_order", who, must);
            other_req = (who == 1) ? m0_read : (m1_read || m1_write);
            must = other_req ? 1 - who : -1;
            if (who == 0) begin
               pr0 = 1'b1; d0 = shadow[m0_address[5:2]];
            end else if (m1_write) begin
               for (int b = 0; b < 4; b++)
                  if (m1_byteenable[b]) shadow[m1_address[5:2]][8*b +: 8] = m1_writedata[8*b +: 8];
            end else begin
               pr1 = 1'b1; d1 = shadow[m1_address[5:2]];
            end
         end
         step();
         if (acc0) m0_read = 1'b0;
         if (acc1) begin m1_read = 1'b0; m1_write = 1'b0; end
      end
      chk("rnd_drained", {m0_read, m1_read, m1_write}, 0);
      chk("rnd_activity", n_acc > 300, 1);
      for (int i = 0; i < 16; i++) chk("rnd_final_mem", mem[8'(8'h80 + i)], shadow[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
